mix_columns_seq: RTL and testbench

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/mix_column_word.sv | 40 ++++
 rtl/mix_columns_seq.sv | 126 ++++++++++++
 tb/tb_mix_columns_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES types and GF(2^8) helpers for the MixColumns
//                datapath. Provides the byte / column-word / state typedefs,
//                the field reduction constant, xtime and multiply-by-3, the
//                column-slice helper and the sequencer state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    // Column index within a state (four 32-bit columns).
    typedef logic [1:0]   col_idx_t;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
    localparam byte_t c_gf_reduce = 8'h1B;

    // Index of the last column; the column counter stops here instead of
    // wrapping so the FSM can leave CALC cleanly.
    localparam col_idx_t c_last_col = 2'd3;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    // Multiply by x in GF(2^8): shift left, fold the carried-out bit back in.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? c_gf_reduce : 8'h00);
    endfunction

    // Multiply by x+1 in GF(2^8).
    function automatic byte_t gf_mul3(input byte_t b);
        return xtime(b) ^ b;
    endfunction

    // Extract column c of a state (column c occupies bits [32c+31:32c]).
    function automatic word_t get_col(input state_t s, input col_idx_t c);
        return s[{c, 5'd0} +: 32];
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/mix_column_word.sv
`default_nettype none
// ============================================================================
//  Module      : mix_column_word
//  Description : Purely combinational forward AES MixColumns of one column.
//                out_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
//  Ports       : col_i  [31:0]  input column, byte r at bits [8r+7:8r]
//                col_o  [31:0]  transformed column, same byte layout
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_column_word
    import aes_pkg::*;
(
    input  word_t col_i,
    output word_t col_o
);

    genvar r;
    generate
        for (r = 0; r < 4; r++) begin : g_row
            // Byte positions of the three neighbours of row r, rotated mod 4.
            localparam int R1 = (r + 1) % 4;
            localparam int R2 = (r + 2) % 4;
            localparam int R3 = (r + 3) % 4;

            byte_t w_a0;
            byte_t w_a1;
            byte_t w_a2;
            byte_t w_a3;

            assign w_a0 = col_i[8*r  +: 8];
            assign w_a1 = col_i[8*R1 +: 8];
            assign w_a2 = col_i[8*R2 +: 8];
            assign w_a3 = col_i[8*R3 +: 8];

            assign col_o[8*r +: 8] = xtime(w_a0) ^ gf_mul3(w_a1) ^ w_a2 ^ w_a3;
        end
    endgenerate

endmodule : mix_column_word
`default_nettype wire

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mix_columns_seq
//  Description : Sequential forward AES MixColumns. Accepts a 128-bit state
//                on a valid/ready handshake, transforms one column per cycle
//                through a single shared mix_column_word instance, then holds
//                the result until the consumer takes it.
//                Timing: handshake edge -> 4 CALC edges -> DONE (out_valid);
//                output handshake -> IDLE; minimum 6 cycles per block.
//  Ports       : clk        clock, rising-edge
//                rst        asynchronous active-high reset
//                in_valid   state_in carries a block
//                in_ready   block can accept (IDLE only)
//                state_in   128-bit input state
//                out_valid  state_out holds a finished result (DONE only)
//                out_ready  consumer accepts state_out
//                state_out  128-bit transformed state
//                busy       FSM not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    mc_state_e state_q, state_d;
    col_idx_t  col_q,   col_d;
    state_t    in_q,    in_d;
    state_t    out_q,   out_d;

    word_t     w_col_in;
    word_t     w_col_out;

    // ------------------------------------------------------------------
    // Shared column datapath: the counter selects which input column is
    // being transformed this cycle.
    // ------------------------------------------------------------------
    assign w_col_in = get_col(in_q, col_q);

    mix_column_word u_mix_column_word (
        .col_i (w_col_in),
        .col_o (w_col_out)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        in_d    = in_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone
                // completes the handshake.
                if (in_valid) begin
                    in_d    = state_in;
                    col_d   = '0;
                    state_d = ST_CALC;
                end
            end

            ST_CALC: begin
                out_d[{col_q, 5'd0} +: 32] = w_col_out;
                // Hold the counter at the last column rather than wrapping;
                // it is cleared again on the next input handshake.
                if (col_q == c_last_col) begin
                    state_d = ST_DONE;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end

            ST_DONE: begin
                // Leaving through IDLE guarantees no input is taken on the
                // output-handshake edge.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded straight from the state register, so they follow
    // the asynchronous reset immediately.
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign state_out = out_q;

endmodule : mix_columns_seq
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mix_columns_seq
//  Description : Self-checking bench for mix_columns_seq. Reference results
//                come from a generic GF(2^8) matrix-multiply model; the
//                inverse matrix is used to confirm the original state comes
//                back from every random result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    // ------------------------------------------------------------------
    // Checking and reference model
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // General GF(2^8) product, reduction polynomial 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix multiply per column; inv selects the inverse matrix.
    function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
        logic [7:0]   cf [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inv) begin
            cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
        end else begin
            cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(cf[(k - row + 4) % 4], s[32*c + 8*k +: 8]);
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with an optional output stall.
    task automatic run_block(input logic [127:0] blk, input int stall, input string tag,
                             input bit use_ref, input logic [127:0] ref_out);
        int           n;
        logic [127:0] exp;
        exp = use_ref ? ref_out : mix_model(blk, 1'b0);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        state_in = blk;
        tick();
        // Garbage on the inputs while busy must be ignored.
        in_valid = 1'($urandom());
        state_in = rand128();
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
            in_valid = 1'($urandom());
            state_in = rand128();
        end
        check({tag, "_latency"}, 128'(n), 128'd4);
        check({tag, "_data"}, state_out, exp);
        check({tag, "_inverse"}, mix_model(state_out, 1'b1), blk);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_data"}, state_out, exp);
            check({tag, "_stall_flags"}, {126'd0, out_valid, in_ready}, 128'b10);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_after_flags"}, {125'd0, busy, out_valid, in_ready}, 128'b001);
        check({tag, "_after_hold"}, state_out, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [127:0] blk;
        logic [127:0] q[$];
        int           hs[$];
        bit           seen;

        rst       = 1'b1;
        in_valid  = 1'b1;   // must not be taken while in reset
        out_ready = 1'b0;
        state_in  = rand128();
        tick();
        tick();
        check("reset_flags", {125'd0, busy, out_valid, in_ready}, 128'b001);
        check("reset_state_out", state_out, 128'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        tick();
        check("post_reset_idle", {125'd0, busy, in_ready}, 128'b01);

        // Known-answer columns (byte r0 in the low byte of each column).
        blk = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
        run_block(blk, 0, "kat4", 1'b1,
                  {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e});

        // Stalled consumer for 10 cycles.
        run_block({4{32'h305dbfd4}}, 10, "stall10", 1'b1, {4{32'he5816604}});

        // Back-to-back blocks with in_valid and out_ready held high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        state_in  = rand128();
        for (int cyc = 0; cyc < 46; cyc++) begin
            if (in_ready) begin
                q.push_back(mix_model(state_in, 1'b0));
                hs.push_back(cyc);
            end
            if (out_valid && q.size() > 0)
                check("b2b_data", state_out, q.pop_front());
            tick();
            state_in = rand128();
        end
        in_valid = 1'b0;
        check("b2b_count", 128'(hs.size() >= 7), 128'd1);
        for (int i = 1; i < hs.size(); i++)
            check("b2b_gap", 128'(hs[i] - hs[i-1]), 128'd6);
        for (int i = 0; i < 8; i++) tick();
        out_ready = 1'b0;
        check("b2b_drained", {126'd0, busy, in_ready}, 128'b01);

        // Reset pulsed while the second column is being computed.
        in_valid = 1'b1;
        state_in = rand128();
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("abort_state_out", state_out, 128'd0);
        check("abort_flags", {125'd0, busy, out_valid, in_ready}, 128'b001);
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        check("abort_no_output", 128'(seen), 128'd0);
        run_block(rand128(), 1, "after_abort", 1'b0, 128'd0);

        // Corner patterns, then random blocks.
        run_block(128'd0, 0, "zeros", 1'b1, 128'd0);
        run_block({128{1'b1}}, 0, "ones", 1'b1, {128{1'b1}});
        for (int i = 0; i < 1000; i++)
            run_block(rand128(), int'($urandom_range(0, 2)), "rand", 1'b0, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mix_columns_seq
`default_nettype wire
